// File: rtl/cpu_debug_slave_cmd_queue.sv
// System-clock side of the CPU debug slave: synchronises JTAG UIR/UDR strobes, queues IR+DR snapshots
// and replays them over valid/ready with one-hot action strobes. Optional counters: DEBUG_CMD_STATS_EN.
module cpu_debug_slave_cmd_queue #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int CMD_DEPTH   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [IR_WIDTH-1:0]                ir_in,
    input  logic [SR_WIDTH-1:0]                sr,
    input  logic                               vs_uir,
    input  logic                               vs_udr,
    output logic                               cmd_valid,
    input  logic                               cmd_ready,
    output logic [IR_WIDTH-1:0]                cmd_ir,
    output logic [SR_WIDTH-1:0]                cmd_data,
    output logic [(2**IR_WIDTH)-1:0]           take_action,
    output logic [(2**IR_WIDTH)-1:0]           take_no_action,
    output logic [$clog2(CMD_DEPTH+1)-1:0]     fifo_level,
    output logic                               overflow,
    input  logic                               overflow_clr
`ifdef DEBUG_CMD_STATS_EN
    ,
    output logic [15:0]                        cmd_count,
    output logic [15:0]                        drop_count
`endif
);

    localparam int N_CH  = 2**IR_WIDTH;
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int LVL_W = $clog2(CMD_DEPTH+1);
    localparam int ENT_W = IR_WIDTH + SR_WIDTH;

    logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
    logic                   uir_dly_q, uir_dly_d;
    logic                   udr_dly_q, udr_dly_d;
    logic [IR_WIDTH-1:0]    ir_q, ir_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [ENT_W-1:0]       head_q, head_d;
    logic [N_CH-1:0]        take_action_q, take_action_d;
    logic [N_CH-1:0]        take_no_action_q, take_no_action_d;
    logic                   overflow_q, overflow_d;
    logic [ENT_W-1:0]       mem_q [CMD_DEPTH];

    logic                   uir_e, udr_e;
    logic                   full, pop, push_ok, drop;
    logic [ENT_W-1:0]       push_entry;
    logic [N_CH-1:0]        head_sel;

    assign uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    assign udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    assign uir_dly_d  = uir_sync_q[SYNC_STAGES-1];
    assign udr_dly_d  = udr_sync_q[SYNC_STAGES-1];
    assign uir_e      = uir_sync_q[SYNC_STAGES-1] & ~uir_dly_q;
    assign udr_e      = udr_sync_q[SYNC_STAGES-1] & ~udr_dly_q;

    // A UIR landing in the same cycle as the UDR supplies the IR for that command.
    assign ir_d       = uir_e ? ir_in : ir_q;
    assign push_entry = {ir_d, sr};

    assign cmd_valid  = (level_q != '0);
    assign full       = (level_q == LVL_W'(CMD_DEPTH));
    assign pop        = cmd_valid & cmd_ready;
    assign push_ok    = udr_e & (~full | pop);
    assign drop       = udr_e & full & ~pop;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_head_sel
            assign head_sel[gi] = (head_q[ENT_W-1 -: IR_WIDTH] == IR_WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        wr_ptr_d         = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d         = rd_ptr_q + PTR_W'(pop);
        level_d          = level_q;
        head_d           = head_q;
        take_action_d    = '0;
        take_no_action_d = '0;
        overflow_d       = overflow_q;

        if (push_ok && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_ok && pop) begin
            level_d = level_q - LVL_W'(1);
        end

        // Head register tracks the next head; new data bypasses the array when it lands there.
        if (level_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_entry;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end

        if (pop) begin
            if (head_q[SR_WIDTH-1]) begin
                take_action_d = head_sel;
            end else begin
                take_no_action_d = head_sel;
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uir_sync_q       <= '1;
            udr_sync_q       <= '1;
            uir_dly_q        <= 1'b1;
            udr_dly_q        <= 1'b1;
            ir_q             <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            head_q           <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            overflow_q       <= 1'b0;
        end else begin
            uir_sync_q       <= uir_sync_d;
            udr_sync_q       <= udr_sync_d;
            uir_dly_q        <= uir_dly_d;
            udr_dly_q        <= udr_dly_d;
            ir_q             <= ir_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            level_q          <= level_d;
            head_q           <= head_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            overflow_q       <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign cmd_ir         = head_q[ENT_W-1 -: IR_WIDTH];
    assign cmd_data       = head_q[SR_WIDTH-1:0];
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign fifo_level     = level_q;
    assign overflow       = overflow_q;

`ifdef DEBUG_CMD_STATS_EN
    logic [15:0] cmd_count_q, cmd_count_d;
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        cmd_count_d  = cmd_count_q;
        drop_count_d = drop_count_q;
        if (push_ok && (cmd_count_q != 16'hFFFF)) begin
            cmd_count_d = cmd_count_q + 16'd1;
        end
        if (drop) begin
            if (overflow_clr) begin
                drop_count_d = 16'd1;
            end else if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end else if (overflow_clr) begin
            drop_count_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            cmd_count_q  <= cmd_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign cmd_count  = cmd_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule
